// File: rtl/btn_press_decoder_if.sv
// btn_press_decoder_if: bundles the button decoder's timebase/level inputs and event outputs.
// Signals:
//   tick         - one-clk timebase strobe (driven by master)
//   clean_btn    - debounced button level, 1 = pressed (driven by master)
//   short_pulse  - one-cycle short-press event (driven by slave)
//   long_pulse   - one-cycle long-press event (driven by slave)
//   repeat_pulse - one-cycle auto-repeat event (driven by slave)
//   held         - button currently being tracked as a press (driven by slave)
// Modports: master = button/timebase side, slave = decoder side.
interface btn_press_decoder_if;
  logic tick;
  logic clean_btn;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;
  modport master (
    output tick, clean_btn,
    input  short_pulse, long_pulse, repeat_pulse, held
  );
  modport slave (
    input  tick, clean_btn,
    output short_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/btn_press_decoder.sv
// btn_press_decoder: turns a debounced button level into short/long/repeat one-cycle events.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset, clears all state and outputs
//   bus   - btn_press_decoder_if.slave (tick, clean_btn in; short_pulse, long_pulse,
//           repeat_pulse, held out; all outputs registered)
// Parameters:
//   LONG_TICKS   - ticks a press must last to be classified long (2..65535)
//   REPEAT_TICKS - tick period of auto-repeat pulses after a long press (1..65535)
// Build option:
//   BTN_REPEAT_EN - when defined, LONG runs the repeat counter and emits repeat_pulse;
//                   otherwise LONG only waits for release and repeat_pulse is constant 0.
module btn_press_decoder #(
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  btn_press_decoder_if.slave   bus
);
  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] LONG    = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          held_q;
`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_TICKS - 1);
  logic          rep_q, rep_d;
`endif
  // saturating increment: the counter must never wrap
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef BTN_REPEAT_EN
    rep_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.clean_btn) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        // release has priority over a coincident threshold tick
        if (!bus.clean_btn) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (bus.tick && cnt_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else if (bus.tick) begin
          cnt_d = cnt_inc;
        end
      end
      LONG: begin
        if (!bus.clean_btn) begin
          state_d = IDLE;
`ifdef BTN_REPEAT_EN
        end else if (bus.tick) begin
          rep_d = (cnt_q == REP_LAST);
          cnt_d = (cnt_q == REP_LAST) ? '0 : cnt_inc;
        end
`else
        end else begin
          cnt_d = '0;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      held_q  <= (state_d != IDLE);
    end
  end
`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_q <= 1'b0;
    else rep_q <= rep_d;
  end
  assign bus.repeat_pulse = rep_q;
`else
  assign bus.repeat_pulse = 1'b0;
`endif
  assign bus.short_pulse = short_q;
  assign bus.long_pulse  = long_q;
  assign bus.held        = held_q;
endmodule

// File: tb/tb_btn_press_decoder.sv
// tb_btn_press_decoder: directed scoreboard bench for btn_press_decoder (LONG_TICKS=5, REPEAT_TICKS=2).
module tb_btn_press_decoder;
  localparam int L = 5;
  localparam int R = 2;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  typedef struct {
    logic [2:0] p;
    logic       h;
    int         n;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  int step = 0;
  exp_t q[$];
  btn_press_decoder_if bus ();
  btn_press_decoder #(.LONG_TICKS(L), .REPEAT_TICKS(R)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] exp_at(input int k);
    logic lp, rp;
    lp = (k == L);
    rp = REP_EN && (k > L) && ((k - L) % R == 0);
    return {rp, lp, 1'b0};
  endfunction
  // drive one cycle of inputs and queue what the DUT must show after the next edge
  task automatic cyc(input logic b, input logic t, input logic [2:0] ep, input logic eh);
    exp_t e;
    @(negedge clk);
    bus.clean_btn = b;
    bus.tick = t;
    step++;
    e.p = ep;
    e.h = eh;
    e.n = step;
    q.push_back(e);
  endtask
  // k ticks while held; gap idle cycles before each tick (gap 0 = tick held high)
  task automatic run_hold(input int n, input int gap);
    for (int k = 1; k <= n; k++) begin
      for (int g = 0; g < gap; g++) cyc(1'b1, 1'b0, 3'b000, 1'b1);
      cyc(1'b1, 1'b1, exp_at(k), 1'b1);
    end
  endtask
  task automatic check_out(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {bus.repeat_pulse, bus.long_pulse, bus.short_pulse, bus.held};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [2:0] obs_p;
      e = q.pop_front();
      obs_p = {bus.repeat_pulse, bus.long_pulse, bus.short_pulse};
      checks++;
      assert (obs_p === e.p) else begin
        errors++;
        $error("FAIL pulses step=%0d observed(rep,long,short)=%b expected=%b", e.n, obs_p, e.p);
      end
      checks++;
      assert (bus.held === e.h) else begin
        errors++;
        $error("FAIL held step=%0d observed=%b expected=%b", e.n, bus.held, e.h);
      end
    end
  end
  initial begin
    bus.clean_btn = 1'b1;
    bus.tick = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_out("reset_hold", 4'b0000);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("first_edge_after_reset", 4'b0001);
    run_hold(3, 1);
    cyc(1'b0, 1'b0, 3'b001, 1'b0);
    cyc(1'b1, 1'b1, 3'b000, 1'b1);
    run_hold(10, 1);
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1);
    run_hold(4, 0);
    cyc(1'b0, 1'b1, 3'b001, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1);
    run_hold(12, 0);
    cyc(1'b0, 1'b1, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1);
    run_hold(3, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_out("reset_mid_hold", 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_out("reenter_after_reset", 4'b0001);
    run_hold(5, 1);
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b0);
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
